// File: rtl/div_op_sequencer.sv
// Operand/result sequencer for the restoring divider: loads A/Q/M over in_bus, captures Q/R from out_bus.
// Optional build macro DIV_ZERO_CHECK_EN short-circuits divisor==0 to a flagged result without touching the divider.
module div_op_sequencer #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [2*W-1:0] op_dividend,
  input  logic [W-1:0]   op_divisor,
  output logic           div_enable,
  output logic           div_start,
  output logic [W-1:0]   in_bus,
  input  logic           q_strobe,
  input  logic           a_strobe,
  input  logic [W-1:0]   out_bus,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_quot,
  output logic [W-1:0]   res_rem,
  output logic           res_err,
  output logic           res_dz
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_LD_A, S_LD_Q, S_LD_M, S_WAIT, S_CAP_Q, S_CAP_A, S_ABORT, S_RESP
  } state_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] dvd;
  logic [W-1:0]   dvs;
  logic [CW-1:0]  wdog;
  logic           accept;
  logic           dz_hit;

  assign accept = op_valid && (state == S_IDLE);

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q;
  assign dz_hit = (op_divisor == '0);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                          dz_q <= 1'b0;
    else if (accept)                     dz_q <= dz_hit;
    else if (state == S_RESP && res_ready) dz_q <= 1'b0;
  end
  assign res_dz = dz_q;
`else
  assign dz_hit = 1'b0;
  assign res_dz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    op_ready   = 1'b0;
    div_enable = 1'b0;
    div_start  = 1'b0;
    in_bus     = '0;
    res_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = dz_hit ? S_RESP : S_START;
      end
      S_START: begin
        div_enable = 1'b1;
        div_start  = 1'b1;
        state_nxt  = S_LD_A;
      end
      S_LD_A: begin
        div_enable = 1'b1;
        in_bus     = dvd[2*W-1:W];
        state_nxt  = S_LD_Q;
      end
      S_LD_Q: begin
        div_enable = 1'b1;
        in_bus     = dvd[W-1:0];
        state_nxt  = S_LD_M;
      end
      S_LD_M: begin
        div_enable = 1'b1;
        in_bus     = dvs;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        // wdog counts completed WAIT cycles; leave on the TIMEOUT-th one
        div_enable = 1'b1;
        if (q_strobe)                         state_nxt = S_CAP_Q;
        else if (wdog == CW'(TIMEOUT - 1))    state_nxt = S_ABORT;
      end
      S_CAP_Q: begin
        div_enable = 1'b1;
        state_nxt  = a_strobe ? S_CAP_A : S_ABORT;
      end
      S_CAP_A: begin
        div_enable = 1'b1;
        state_nxt  = S_RESP;
      end
      S_ABORT: state_nxt = S_RESP;
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dvd      <= '0;
      dvs      <= '0;
      wdog     <= '0;
      res_quot <= '0;
      res_rem  <= '0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        dvd <= op_dividend;
        dvs <= op_divisor;
        if (dz_hit) begin
          res_quot <= '1;
          res_rem  <= op_dividend[W-1:0];
        end
      end
      case (state)
        S_LD_M:  wdog     <= '0;
        S_WAIT:  wdog     <= wdog + CW'(1);
        S_CAP_Q: res_quot <= out_bus;
        S_CAP_A: res_rem  <= out_bus;
        S_ABORT: begin
          res_quot <= '0;
          res_rem  <= '0;
          res_err  <= 1'b1;
        end
        S_RESP:  if (res_ready) res_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
